// File: rtl/pattern_stream_gen_pkg.sv
// Shared constants, state encoding and helpers for the pattern stream generator.
package pattern_stream_gen_pkg;

  localparam int unsigned PatW    = 8;
  localparam int unsigned LenW    = 4;
  localparam int unsigned RepW    = 4;
  localparam int unsigned GapW    = 3;
  localparam int unsigned IdxW    = 3;
  localparam int unsigned SymCntW = 8;

  localparam logic CAR  = 1'b0;
  localparam logic BIKE = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StEmit,
    StGap,
    StDone
  } state_e;

  // Lengths above the pattern width wrap nothing; they simply use the whole pattern.
  function automatic logic [LenW-1:0] clamp_len(input logic [LenW-1:0] len);
    return (len > LenW'(PatW)) ? LenW'(PatW) : len;
  endfunction

endpackage

// File: rtl/pattern_stream_gen_if.sv
// Control and symbol-stream signals of the pattern stream generator.
interface pattern_stream_gen_if;
  import pattern_stream_gen_pkg::*;

  logic               start;
  logic [PatW-1:0]    pat;
  logic [LenW-1:0]    pat_len;
  logic [RepW-1:0]    rep_cnt;
  logic [GapW-1:0]    gap;
  logic               hold;
  logic               d_out;
  logic               valid_out;
  logic               busy;
  logic               done;
  logic [SymCntW-1:0] sym_cnt;

  modport master (
    input  start, pat, pat_len, rep_cnt, gap, hold,
    output d_out, valid_out, busy, done, sym_cnt
  );

  modport slave (
    output start, pat, pat_len, rep_cnt, gap, hold,
    input  d_out, valid_out, busy, done, sym_cnt
  );

endinterface

// File: rtl/pattern_stream_gen.sv
// Emits a latched bit pattern a configurable number of times, with idle gaps and a hold input.
module pattern_stream_gen
  import pattern_stream_gen_pkg::*;
(
  input logic                 clk,
  input logic                 reset,
  pattern_stream_gen_if.master bus
);

  state_e             state_q, state_d;
  logic [PatW-1:0]    pat_q, pat_d;
  logic [LenW-1:0]    len_q, len_d;
  logic [RepW-1:0]    rep_q, rep_d;  // repetitions left, including the current one
  logic [GapW-1:0]    gap_q, gap_d;
  logic [GapW-1:0]    gap_left_q, gap_left_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic [SymCntW-1:0] cnt_q, cnt_d;
  logic               d_out_q, d_out_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               emit;

  always_comb begin
    state_d    = state_q;
    pat_d      = pat_q;
    len_d      = len_q;
    rep_d      = rep_q;
    gap_d      = gap_q;
    gap_left_d = gap_left_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    d_out_d    = 1'b0;
    valid_d    = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    emit       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start && (bus.pat_len != '0) && (bus.rep_cnt != '0)) begin
          pat_d = bus.pat;
          len_d = clamp_len(bus.pat_len);
          rep_d = bus.rep_cnt;
          gap_d = bus.gap;
          idx_d = '0;
          cnt_d = '0;
          emit  = 1'b1;
        end
      end
      StEmit: begin
        busy_d = 1'b1;
        emit   = !bus.hold;
      end
      StGap: begin
        busy_d = 1'b1;
        if (!bus.hold) begin
          if (gap_left_q <= GapW'(1)) begin
            state_d = StEmit;
            idx_d   = '0;
          end else begin
            gap_left_d = gap_left_q - GapW'(1);
          end
        end
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // The accepting edge already presents symbol 0, so emission reads the *_d copies.
    if (emit) begin
      busy_d  = 1'b1;
      valid_d = 1'b1;
      d_out_d = pat_d[idx_d];
      cnt_d   = cnt_d + SymCntW'(1);
      if ({1'b0, idx_d} == len_d - LenW'(1)) begin
        idx_d = '0;
        if (rep_d == RepW'(1)) begin
          state_d = StDone;
        end else begin
          rep_d = rep_d - RepW'(1);
          if (gap_d == '0) begin
            state_d = StEmit;
          end else begin
            state_d    = StGap;
            gap_left_d = gap_d;
          end
        end
      end else begin
        idx_d   = idx_d + IdxW'(1);
        state_d = StEmit;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      pat_q      <= '0;
      len_q      <= '0;
      rep_q      <= '0;
      gap_q      <= '0;
      gap_left_q <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      d_out_q    <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pat_q      <= pat_d;
      len_q      <= len_d;
      rep_q      <= rep_d;
      gap_q      <= gap_d;
      gap_left_q <= gap_left_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      d_out_q    <= d_out_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.d_out     = d_out_q;
  assign bus.valid_out = valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.sym_cnt   = cnt_q;

endmodule

// File: tb/tb_pattern_stream_gen.sv
// Scoreboard bench: stimulus builds a per-cycle expected timeline, a monitor compares every cycle.
module tb_pattern_stream_gen;
  import pattern_stream_gen_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;

  pattern_stream_gen_if bus();

  pattern_stream_gen dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    int cyc;
    bit v;
    bit d;
    bit b;
    bit dn;
    int cnt;
  } exp_t;

  exp_t exp_q[$];
  int   exp_idle_cnt = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   mon_on = 1'b0;

  task automatic check(input string name, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, edge_n, got, want);
    end
  endtask

  function automatic void push_exp(input int cyc, input bit v, input bit d, input bit b,
                                   input bit dn, input int cnt);
    exp_t e;
    e.cyc = cyc; e.v = v; e.d = d; e.b = b; e.dn = dn; e.cnt = cnt;
    exp_q.push_back(e);
  endfunction

  // Monitor: runs at each falling edge, before stimulus (which waits #1 more).
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        while (exp_q.size() > 0 && exp_q[0].cyc < edge_n) begin
          check("missed_cycle", edge_n, exp_q[0].cyc);
          void'(exp_q.pop_front());
        end
        if (exp_q.size() > 0 && exp_q[0].cyc == edge_n) begin
          e = exp_q.pop_front();
          check("valid_out", int'(bus.valid_out), int'(e.v));
          check("d_out", int'(bus.d_out), int'(e.d));
          check("busy", int'(bus.busy), int'(e.b));
          check("done", int'(bus.done), int'(e.dn));
          check("sym_cnt", int'(bus.sym_cnt), e.cnt);
        end else begin
          check("idle_valid_out", int'(bus.valid_out), 0);
          check("idle_d_out", int'(bus.d_out), 0);
          check("idle_busy", int'(bus.busy), 0);
          check("idle_done", int'(bus.done), 0);
          check("idle_sym_cnt", int'(bus.sym_cnt), exp_idle_cnt);
        end
      end
    end
  end

  // hmode: 0 no hold, 1 random hold, 2 hold from mask (bit i = edge i after acceptance).
  task automatic run_stream(input logic [7:0] p, input logic [3:0] pl, input logic [3:0] rc,
                            input logic [2:0] gp, input int hmode, input logic [31:0] mask,
                            input int abort_at);
    bit sv[$];
    bit sb[$];
    int len;
    int cnt;
    int base;
    bit h;
    bit s_v;
    bit s_b;
    len = (pl > 8) ? 8 : int'(pl);
    @(negedge clk); #1;
    bus.start = 1'b1; bus.pat = p; bus.pat_len = pl; bus.rep_cnt = rc; bus.gap = gp;
    bus.hold = 1'($urandom_range(0, 1));
    if (pl == 0 || rc == 0) begin
      @(negedge clk); #1;
      bus.start = 1'b0;
      return;
    end
    for (int r = 0; r < int'(rc); r++) begin
      for (int b = 0; b < len; b++) begin
        sv.push_back(1'b1);
        sb.push_back(p[b]);
      end
      if (r < int'(rc) - 1) begin
        for (int g = 0; g < int'(gp); g++) begin
          sv.push_back(1'b0);
          sb.push_back(1'b0);
        end
      end
    end
    base = edge_n + 1;
    void'(sv.pop_front());
    s_b = sb.pop_front();
    cnt = 1;
    push_exp(base, 1'b1, s_b, 1'b1, 1'b0, cnt);
    for (int i = 1; ; i++) begin
      @(negedge clk); #1;
      bus.start = 1'($urandom_range(0, 1));
      bus.pat = 8'($urandom);
      bus.pat_len = 4'($urandom);
      bus.rep_cnt = 4'($urandom);
      bus.gap = 3'($urandom);
      if (i == abort_at) begin
        reset = 1'b1;
        bus.hold = 1'b0;
        exp_q.delete();
        exp_idle_cnt = 0;
        @(negedge clk); #1;
        reset = 1'b0;
        bus.start = 1'b0;
        return;
      end
      if (sv.size() == 0) begin
        bus.hold = 1'($urandom_range(0, 1));
        push_exp(base + i, 1'b0, 1'b0, 1'b0, 1'b1, cnt);
        exp_idle_cnt = cnt;
        break;
      end
      case (hmode)
        1:       h = ($urandom_range(0, 3) == 0);
        2:       h = (i < 32) ? mask[i] : 1'b0;
        default: h = 1'b0;
      endcase
      bus.hold = h;
      if (h) begin
        push_exp(base + i, 1'b0, 1'b0, 1'b1, 1'b0, cnt);
      end else begin
        s_v = sv.pop_front();
        s_b = sb.pop_front();
        if (s_v) cnt++;
        push_exp(base + i, s_v, s_v & s_b, 1'b1, 1'b0, cnt);
      end
    end
    @(negedge clk); #1;
    bus.start = 1'b0;
    bus.hold = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0; bus.pat = '0; bus.pat_len = '0; bus.rep_cnt = '0; bus.gap = '0;
    bus.hold = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    reset = 1'b0;
    mon_on = 1'b1;
    repeat (2) @(negedge clk);

    run_stream(8'h0B, 4'd5, 4'd1, 3'd0, 0, 32'h0, -1);
    run_stream(8'h0B, 4'd5, 4'd3, 3'd2, 0, 32'h0, -1);
    run_stream(8'h0B, 4'd5, 4'd1, 3'd0, 2, 32'h1C, -1);
    run_stream(8'h0B, 4'd0, 4'd3, 3'd1, 0, 32'h0, -1);
    run_stream(8'h0B, 4'd5, 4'd0, 3'd1, 0, 32'h0, -1);
    run_stream(8'hA5, 4'd6, 4'd2, 3'd1, 0, 32'h0, 2);
    run_stream(8'h0B, 4'd5, 4'd1, 3'd0, 0, 32'h0, -1);
    run_stream(8'h6C, 4'd12, 4'd15, 3'd0, 0, 32'h0, -1);
    run_stream(8'h81, 4'd1, 4'd4, 3'd3, 1, 32'h0, -1);

    for (int t = 0; t < 30; t++) begin
      run_stream(8'($urandom), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 6)),
                 3'($urandom_range(0, 7)), int'($urandom_range(0, 1)), 32'h0,
                 ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 20)) : -1);
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk); #1;
        bus.hold = 1'($urandom_range(0, 1));
      end
    end

    repeat (3) @(negedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
